// File: rtl/fir_coefficient_loader_if.sv
// Purpose: AXI-Stream coefficient channel between the bank loader and the FIR coefficient input.
// Ports: tdata/tvalid/tlast are driven by the master (loader) and tready by the slave (FIR).
// Modports: master = loader side, slave = filter side.
interface fir_coefficient_loader_if #(
  parameter int COEFFICIENT_WIDTH = 16
);
  logic [COEFFICIENT_WIDTH-1:0] tdata;
  logic                         tvalid;
  logic                         tlast;
  logic                         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/fir_coefficient_loader.sv
// Purpose: stores NUMBER_BANKS x NUMBER_TAPS coefficients written over a register port and
//          streams one selected bank, tap 0 first, as an AXIS burst with tlast on the final tap.
// Latency: first beat one cycle after an accepted load_req; load_done one cycle after the last beat.
// Backpressure: tdata/tlast are registered and held while tready is low; nothing is dropped or repeated.
// Ports: coefficients_out_aclk/aresetn (clock, async active-low reset), wr_* (coefficient write port,
//        wr_error pulse on a dropped write), load_* (burst request/status), active_bank (last bank
//        fully streamed), coefficients_out (AXIS master toward the FIR coefficient input).
module fir_coefficient_loader #(
  parameter  int NUMBER_TAPS       = 16,
  parameter  int COEFFICIENT_WIDTH = 16,
  parameter  int NUMBER_BANKS      = 4,
  localparam int BANK_W            = (NUMBER_BANKS > 1) ? $clog2(NUMBER_BANKS) : 1,
  localparam int TAP_W             = $clog2(NUMBER_TAPS)
) (
  input  logic                         coefficients_out_aclk,
  input  logic                         coefficients_out_aresetn,

  input  logic                         wr_en,
  input  logic [BANK_W-1:0]            wr_bank,
  input  logic [TAP_W-1:0]             wr_addr,
  input  logic [COEFFICIENT_WIDTH-1:0] wr_data,
  output logic                         wr_error,

  input  logic                         load_req,
  input  logic [BANK_W-1:0]            load_bank,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_error,
  output logic [BANK_W-1:0]            active_bank,

  fir_coefficient_loader_if.master     coefficients_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Coefficient store. Deliberately not reset: the host always writes a bank before using it.
  logic [COEFFICIENT_WIDTH-1:0] coeff_mem [NUMBER_BANKS][NUMBER_TAPS];

  state_t                       state_q, state_d;
  logic [TAP_W-1:0]             tap_q, tap_d;
  logic [BANK_W-1:0]            bank_q, bank_d;
  logic [COEFFICIENT_WIDTH-1:0] tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;
  logic [BANK_W-1:0]            active_bank_q, active_bank_d;
  logic                         wr_error_q, wr_error_d;
  logic                         load_error_q, load_error_d;

  logic                         wr_bank_ok;
  logic                         wr_addr_ok;
  logic                         wr_conflict;
  logic                         wr_accept;
  logic                         load_bank_ok;
  logic                         beat_taken;
  logic                         last_beat;
  logic                         tap0_bypass;
  logic [TAP_W-1:0]             tap_next;
  logic [BANK_W-1:0]            rd_bank;
  logic [TAP_W-1:0]             rd_tap;
  logic [COEFFICIENT_WIDTH-1:0] rd_data;

  // ---------------------------------------------------------------------------
  // Write qualification and store read port
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_bank_ok   = int'(wr_bank) < NUMBER_BANKS;
    wr_addr_ok   = int'(wr_addr) < NUMBER_TAPS;
    // A bank is frozen while it is on the wire so a burst is always self-consistent.
    wr_conflict  = (state_q == ST_STREAM) && (wr_bank == bank_q);
    wr_accept    = wr_en && wr_bank_ok && wr_addr_ok && !wr_conflict;

    load_bank_ok = int'(load_bank) < NUMBER_BANKS;
    beat_taken   = tvalid_q && coefficients_out.tready;
    last_beat    = int'(tap_q) == (NUMBER_TAPS - 1);
    tap_next     = tap_q + TAP_W'(1);

    // In IDLE the read port looks ahead at tap 0 of the requested bank; while
    // streaming it fetches the tap that follows the one currently presented.
    if (state_q == ST_IDLE) begin
      rd_bank = load_bank;
      rd_tap  = '0;
    end else begin
      rd_bank = bank_q;
      rd_tap  = tap_next;
    end
    rd_data = coeff_mem[rd_bank][rd_tap];

    // A write to tap 0 of the bank being requested in the same cycle has not
    // reached the store yet; forward it so the burst carries the new value.
    tap0_bypass = wr_accept && (wr_bank == load_bank) && (wr_addr == '0);
  end

  always_ff @(posedge coefficients_out_aclk) begin
    if (wr_accept) begin
      coeff_mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    bank_d        = bank_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    active_bank_d = active_bank_q;
    wr_error_d    = wr_en && !wr_accept;
    load_error_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          if (load_bank_ok) begin
            state_d  = ST_STREAM;
            bank_d   = load_bank;
            tap_d    = '0;
            tvalid_d = 1'b1;
            // At least two taps per bank, so tap 0 is never the last beat.
            tlast_d  = 1'b0;
            tdata_d  = tap0_bypass ? wr_data : rd_data;
          end else begin
            load_error_d = 1'b1;
          end
        end
      end

      ST_STREAM: begin
        // A burst in flight is never pre-empted; late requests are rejected.
        load_error_d = load_req;
        if (beat_taken) begin
          if (last_beat) begin
            state_d       = ST_DONE;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            // Published together with load_done so the done pulse and the
            // new active bank can be sampled in the same cycle.
            active_bank_d = bank_q;
          end else begin
            tap_d   = tap_next;
            tdata_d = rd_data;
            tlast_d = int'(tap_next) == (NUMBER_TAPS - 1);
          end
        end
      end

      ST_DONE: begin
        load_error_d = load_req;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge coefficients_out_aclk or negedge coefficients_out_aresetn) begin
    if (!coefficients_out_aresetn) begin
      state_q       <= ST_IDLE;
      tap_q         <= '0;
      bank_q        <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      active_bank_q <= '0;
      wr_error_q    <= 1'b0;
      load_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      bank_q        <= bank_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      active_bank_q <= active_bank_d;
      wr_error_q    <= wr_error_d;
      load_error_q  <= load_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign coefficients_out.tdata  = tdata_q;
  assign coefficients_out.tvalid = tvalid_q;
  assign coefficients_out.tlast  = tlast_q;

  assign wr_error    = wr_error_q;
  assign load_error  = load_error_q;
  assign load_busy   = (state_q != ST_IDLE);
  assign load_done   = (state_q == ST_DONE);
  assign active_bank = active_bank_q;

endmodule

// File: tb/tb_fir_coefficient_loader.sv
// Purpose: self-checking bench for fir_coefficient_loader (16 taps, 16-bit, 3 banks).
// Latency: n/a (bench).
// Backpressure: tready driven both in directed stall windows and randomly.
module tb_fir_coefficient_loader;
  localparam int NT = 16;
  localparam int CW = 16;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_bank;
  logic [3:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic          wr_error;
  logic          load_req;
  logic [1:0]    load_bank;
  logic          load_busy;
  logic          load_done;
  logic          load_error;
  logic [1:0]    active_bank;

  fir_coefficient_loader_if #(.COEFFICIENT_WIDTH(CW)) axis_if ();

  fir_coefficient_loader #(
    .NUMBER_TAPS      (NT),
    .COEFFICIENT_WIDTH(CW),
    .NUMBER_BANKS     (NB)
  ) dut (
    .coefficients_out_aclk   (clk),
    .coefficients_out_aresetn(rst_n),
    .wr_en                   (wr_en),
    .wr_bank                 (wr_bank),
    .wr_addr                 (wr_addr),
    .wr_data                 (wr_data),
    .wr_error                (wr_error),
    .load_req                (load_req),
    .load_bank               (load_bank),
    .load_busy               (load_busy),
    .load_done               (load_done),
    .load_error              (load_error),
    .active_bank             (active_bank),
    .coefficients_out        (axis_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a copy of the store plus a queue holding the rest of the
  // burst being streamed. The head of the queue is what must be on the wire.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] m_mem [NB][NT];
  logic [CW-1:0] m_q [$];
  int            m_bank   = 0;
  bit            m_done   = 0;
  int            m_active = 0;
  bit            m_wrerr  = 0;
  bit            m_lderr  = 0;

  function automatic void model_reset();
    m_q.delete();
    m_bank   = 0;
    m_done   = 0;
    m_active = 0;
    m_wrerr  = 0;
    m_lderr  = 0;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void model_update();
    bit streaming;
    bit busy;
    bit wr_ok;
    bit next_done;
    streaming = (m_q.size() > 0);
    busy      = streaming || m_done;
    wr_ok     = wr_en && (int'(wr_bank) < NB) && !(streaming && int'(wr_bank) == m_bank);
    m_wrerr   = wr_en && !wr_ok;
    m_lderr   = load_req && (busy || int'(load_bank) >= NB);
    next_done = 0;
    if (wr_ok) m_mem[wr_bank][wr_addr] = wr_data;
    if (streaming && axis_if.tready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        next_done = 1;
        m_active  = m_bank;
      end
    end
    if (!busy && load_req && int'(load_bank) < NB) begin
      m_bank = int'(load_bank);
      for (int t = 0; t < NT; t++) m_q.push_back(m_mem[load_bank][t]);
    end
    m_done = next_done;
  endfunction

  // One compare process, clear of the active edge.
  always @(posedge clk) begin
    #1;
    chk("tvalid", axis_if.tvalid, m_q.size() > 0);
    chk("tlast", axis_if.tlast, m_q.size() == 1);
    if (m_q.size() > 0) chk("tdata", axis_if.tdata, m_q[0]);
    chk("load_busy", load_busy, (m_q.size() > 0) || m_done);
    chk("load_done", load_done, m_done);
    chk("wr_error", wr_error, m_wrerr);
    chk("load_error", load_error, m_lderr);
    if (!m_done) chk("active_bank", active_bank, m_active);
  end

  task automatic tick();
    if (rst_n) model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [1:0] b, input logic [3:0] a, input logic [CW-1:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Directed burst driver: records beats, stall-cycle data and error pulses.
  logic [CW-1:0] beat_q [$];
  int            beat_cyc_q [$];
  int            last_idx_q [$];
  logic [CW-1:0] stall_q [$];
  int            done_cyc;
  int            n_lderr;
  int            n_wrerr;

  task automatic do_burst(input logic [1:0] bank, input int stall_lo, input int stall_hi,
                          input int err_cyc, input int wa_cyc, input logic [1:0] wa_bank,
                          input logic [CW-1:0] wa_data, input int wb_cyc,
                          input logic [1:0] wb_bank, input logic [CW-1:0] wb_data);
    int cyc;
    beat_q.delete(); beat_cyc_q.delete(); last_idx_q.delete(); stall_q.delete();
    done_cyc = -1; n_lderr = 0; n_wrerr = 0; cyc = 0;
    while (cyc < 80 && done_cyc < 0) begin
      axis_if.tready = !(cyc >= stall_lo && cyc <= stall_hi);
      load_req  = (cyc == 0) || (cyc == err_cyc);
      load_bank = (cyc == 0) ? bank : 2'd2;
      wr_en     = (cyc == wa_cyc) || (cyc == wb_cyc);
      wr_bank   = (cyc == wb_cyc) ? wb_bank : wa_bank;
      wr_data   = (cyc == wb_cyc) ? wb_data : wa_data;
      wr_addr   = 4'd0;
      if (cyc > 0) begin
        if (axis_if.tvalid && axis_if.tready) begin
          if (axis_if.tlast) last_idx_q.push_back(beat_q.size());
          beat_q.push_back(axis_if.tdata);
          beat_cyc_q.push_back(cyc);
        end
        if (axis_if.tvalid && !axis_if.tready) stall_q.push_back(axis_if.tdata);
        if (load_error) n_lderr++;
        if (wr_error) n_wrerr++;
        if (load_done) done_cyc = cyc;
      end
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    chk("burst_done_seen", done_cyc >= 0, 1);
    load_req = 1'b0; wr_en = 1'b0; axis_if.tready = 1'b1;
    tick();
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    load_req = 1'b0; load_bank = '0; axis_if.tready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tvalid", axis_if.tvalid, 0);
    chk("rst_tdata", axis_if.tdata, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_active", active_bank, 0);
    rst_n = 1'b1;
    tick();

    // Fill every tap of every bank; bank1 gets the 0x0100+i ramp.
    for (int b = 0; b < NB; b++)
      for (int t = 0; t < NT; t++)
        write(2'(b), 4'(t), (b == 1) ? 16'(16'h0100 + t) : 16'($urandom));

    // 1: plain burst of bank1.
    do_burst(2'd1, -1, -1, -1, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t1_beats", beat_q.size(), 16);
    for (int i = 0; i < beat_q.size(); i++) chk("t1_data", beat_q[i], 32'h0100 + i);
    chk("t1_first_cyc", beat_cyc_q[0], 1);
    chk("t1_last_cyc", beat_cyc_q[beat_cyc_q.size()-1], 16);
    chk("t1_tlast_cnt", last_idx_q.size(), 1);
    chk("t1_tlast_pos", last_idx_q[0], 15);
    chk("t1_done_cyc", done_cyc, 17);
    chk("t1_active", active_bank, 1);

    // 2: stall on cycles 3-5.
    do_burst(2'd1, 3, 5, -1, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t2_beats", beat_q.size(), 16);
    for (int i = 0; i < beat_q.size(); i++) chk("t2_data", beat_q[i], 32'h0100 + i);
    chk("t2_stall_cnt", stall_q.size(), 3);
    foreach (stall_q[i]) chk("t2_stall_data", stall_q[i], 32'h0102);
    chk("t2_done_cyc", done_cyc, 20);

    // 3: second request mid-burst is rejected.
    do_burst(2'd1, -1, -1, 5, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t3_beats", beat_q.size(), 16);
    chk("t3_last_data", beat_q[15], 32'h010F);
    chk("t3_lderr", n_lderr, 1);
    chk("t3_done_cyc", done_cyc, 17);
    repeat (3) begin
      tick();
      chk("t3_no_second", axis_if.tvalid, 0);
    end

    // 4: write to the streamed bank is dropped, other bank lands.
    do_burst(2'd1, -1, -1, -1, 4, 2'd1, 16'hFFFF, 6, 2'd2, 16'h1234);
    chk("t4_wrerr", n_wrerr, 1);
    do_burst(2'd1, -1, -1, -1, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t4_bank1_tap0", beat_q[0], 32'h0100);
    do_burst(2'd2, -1, -1, -1, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t4_bank2_tap0", beat_q[0], 32'h1234);
    chk("t4_active", active_bank, 2);

    // Write and load of the same bank in the same IDLE cycle: new value streams.
    do_burst(2'd2, -1, -1, -1, 0, 2'd2, 16'hBEEF, -1, 2'd0, 16'h0);
    chk("byp_tap0", beat_q[0], 32'hBEEF);
    chk("byp_wrerr", n_wrerr, 0);

    // 5: reset during beat 7.
    load_bank = 2'd1; load_req = 1'b1; axis_if.tready = 1'b1;
    tick();
    load_req = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (axis_if.tvalid && axis_if.tdata == 16'h0106) found = 1;
      else tick();
    end
    chk("t5_reach_beat7", found, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_tvalid", axis_if.tvalid, 0);
    chk("t5_busy", load_busy, 0);
    chk("t5_tlast", axis_if.tlast, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_burst(2'd1, -1, -1, -1, -1, 2'd0, 16'h0, -1, 2'd0, 16'h0);
    chk("t5_beats", beat_q.size(), 16);
    for (int i = 0; i < beat_q.size(); i++) chk("t5_data", beat_q[i], 32'h0100 + i);

    // 6: out-of-range bank for load and write.
    load_bank = 2'd3; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("t6_lderr", load_error, 1);
    chk("t6_tvalid", axis_if.tvalid, 0);
    tick();
    chk("t6_lderr_pulse", load_error, 0);
    chk("t6_tvalid2", axis_if.tvalid, 0);
    write(2'd3, 4'd5, 16'hAAAA);
    chk("t6_wrerr", wr_error, 1);
    tick();
    chk("t6_wrerr_pulse", wr_error, 0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr_en          = ($urandom_range(0, 3) == 0);
      wr_bank        = 2'($urandom_range(0, 3));
      wr_addr        = 4'($urandom_range(0, 15));
      wr_data        = 16'($urandom);
      load_req       = ($urandom_range(0, 7) == 0);
      load_bank      = 2'($urandom_range(0, 3));
      axis_if.tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_en = 1'b0; load_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
